lfsr_seq_ctrl: RTL and testbench

- AXI-Lite master sequencer that programs and runs the 8-bit LFSR stream peripheral for one command at a time.
- Per command it:
  - writes stop=0, seed, taps and start=1 over AXI-Lite;
  - forwards exactly N stream beats from the peripheral to a downstream sink;
  - writes stop=1 and start=0;
  - pulses done with status.
- Sits between a host/test controller and the LFSR peripheral; it is the peripheral's only AXI-Lite master.

---
 rtl/lfsr_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - AXI-Lite sequencer that programs the LFSR stream peripheral and forwards N beats per command.
// One command at a time: stop=0, seed, taps, start=1, stream N beats, stop=1, start=0, done pulse.
module lfsr_seq_ctrl #(
  parameter int                           C_AXIL_ADDR_WIDTH = 4,
  parameter int                           C_AXIL_DATA_WIDTH = 32,
  parameter logic [C_AXIL_ADDR_WIDTH-1:0] BASE_ADDR         = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_seed,
  input  logic [7:0]                   cmd_taps,
  input  logic [15:0]                  cmd_count,
  input  logic                         abort,
  output logic                         done,
  output logic                         status_err,
  output logic [15:0]                  status_beats,
  output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [C_AXIL_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [C_AXIL_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_STOP0 = 4'd1,
    WR_SEED  = 4'd2,
    WR_TAPS  = 4'd3,
    WR_START = 4'd4,
    STREAM   = 4'd5,
    WR_STOP1 = 4'd6,
    WR_CLR   = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam logic [C_AXIL_ADDR_WIDTH-1:0] OFF_START = C_AXIL_ADDR_WIDTH'(4'h0);
  localparam logic [C_AXIL_ADDR_WIDTH-1:0] OFF_STOP  = C_AXIL_ADDR_WIDTH'(4'h4);
  localparam logic [C_AXIL_ADDR_WIDTH-1:0] OFF_SEED  = C_AXIL_ADDR_WIDTH'(4'h8);
  localparam logic [C_AXIL_ADDR_WIDTH-1:0] OFF_TAPS  = C_AXIL_ADDR_WIDTH'(4'hC);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_seed;
  logic [7:0]  r_taps;
  logic [15:0] r_count;
  logic [15:0] r_beats;
  logic        r_err;
  logic        r_aw_done;
  logic        r_w_done;

  logic                         w_wr_state;
  logic                         w_in_stream;
  logic                         w_cmd_fire;
  logic                         w_aw_fire;
  logic                         w_w_fire;
  logic                         w_b_fire;
  logic                         w_beat;
  logic [15:0]                  w_beats_nxt;
  logic [C_AXIL_ADDR_WIDTH-1:0] w_off;
  logic [C_AXIL_DATA_WIDTH-1:0] w_wdata;

  assign w_wr_state  = (r_state == WR_STOP0) || (r_state == WR_SEED) || (r_state == WR_TAPS) ||
                       (r_state == WR_START) || (r_state == WR_STOP1) || (r_state == WR_CLR);
  assign w_in_stream = (r_state == STREAM);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_aw_fire   = m_axi_awvalid && m_axi_awready;
  assign w_w_fire    = m_axi_wvalid && m_axi_wready;
  assign w_b_fire    = m_axi_bvalid && m_axi_bready;
  assign w_beat      = w_in_stream && s_axis_tvalid && m_axis_tready;
  assign w_beats_nxt = r_beats + 16'd1;

  // Register target and payload for the write owned by the current state.
  always_comb begin
    w_off   = '0;
    w_wdata = '0;
    case (r_state)
      WR_STOP0: begin w_off = OFF_STOP;  w_wdata = '0; end
      WR_SEED:  begin w_off = OFF_SEED;  w_wdata = C_AXIL_DATA_WIDTH'(r_seed); end
      WR_TAPS:  begin w_off = OFF_TAPS;  w_wdata = C_AXIL_DATA_WIDTH'(r_taps); end
      WR_START: begin w_off = OFF_START; w_wdata = C_AXIL_DATA_WIDTH'(1); end
      WR_STOP1: begin w_off = OFF_STOP;  w_wdata = C_AXIL_DATA_WIDTH'(1); end
      WR_CLR:   begin w_off = OFF_START; w_wdata = '0; end
      default:  begin w_off = '0;        w_wdata = '0; end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_cmd_fire) w_next_state = WR_STOP0;
      WR_STOP0: if (w_b_fire)   w_next_state = WR_SEED;
      WR_SEED:  if (w_b_fire)   w_next_state = WR_TAPS;
      WR_TAPS:  if (w_b_fire)   w_next_state = WR_START;
      WR_START: if (w_b_fire)   w_next_state = (r_count == 16'd0) ? WR_STOP1 : STREAM;
      STREAM:   if (abort || (w_beat && (w_beats_nxt == r_count))) w_next_state = WR_STOP1;
      WR_STOP1: if (w_b_fire)   w_next_state = WR_CLR;
      WR_CLR:   if (w_b_fire)   w_next_state = DONE;
      DONE:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_seed    <= '0;
      r_taps    <= '0;
      r_count   <= '0;
      r_beats   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cmd_fire) begin
        r_seed  <= cmd_seed;
        r_taps  <= cmd_taps;
        r_count <= cmd_count;
        r_beats <= '0;
        r_err   <= 1'b0;
      end
      // bready only rises after both channels are done, so b never overlaps an aw/w handshake.
      if (w_wr_state) begin
        if (w_b_fire) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (m_axi_bresp != 2'b00) r_err <= 1'b1;
        end else begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire)  r_w_done  <= 1'b1;
        end
      end
      if (w_beat) r_beats <= w_beats_nxt;
    end
  end

  assign cmd_ready     = (r_state == IDLE);
  assign m_axi_awvalid = w_wr_state && !r_aw_done;
  assign m_axi_wvalid  = w_wr_state && !r_w_done;
  assign m_axi_bready  = w_wr_state && r_aw_done && r_w_done;
  assign m_axi_awaddr  = w_wr_state ? (BASE_ADDR + w_off) : '0;
  assign m_axi_wdata   = w_wr_state ? w_wdata : '0;

  // Outside STREAM the peripheral output is drained and discarded.
  assign m_axis_tdata  = w_in_stream ? s_axis_tdata : '0;
  assign m_axis_tvalid = w_in_stream && s_axis_tvalid;
  assign s_axis_tready = w_in_stream ? m_axis_tready : 1'b1;

  assign done          = (r_state == DONE);
  assign status_err    = r_err;
  assign status_beats  = r_beats;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - self-checking bench for lfsr_seq_ctrl with AXI-Lite slave, stream source and sink models.
module tb_lfsr_seq_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_seed, cmd_taps;
  logic [15:0]   cmd_count;
  logic          abort, done, status_err;
  logic [15:0]   status_beats;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;

  always #5 aclk = ~aclk;

  lfsr_seq_ctrl #(.C_AXIL_ADDR_WIDTH(AW), .C_AXIL_DATA_WIDTH(DW), .BASE_ADDR('0)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed), .cmd_taps(cmd_taps),
    .cmd_count(cmd_count), .abort(abort), .done(done), .status_err(status_err),
    .status_beats(status_beats),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // AXI-Lite slave / peripheral model
  bit          aw_got, w_got, in_wr;
  int          wcyc, aw_lat, w_lat, b_wait, lat_mode, wr_idx;
  bit          err_on_taps, per_start, per_stop;
  logic [31:0] cap_addr, cap_data;
  logic [63:0] wlog[$];
  // Stream source / sink model
  bit          src_valid, snk_ready;
  logic [31:0] src_data;
  int          snk_mode, cyc, abort_at, done_cnt;
  logic [31:0] sent[$];
  logic [31:0] recv[$];
  bit          acc, st_err;
  logic [15:0] st_beats;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pick_lat();
    case (lat_mode)
      1: begin
        aw_lat = (wr_idx % 2 == 0) ? 3 : 0;
        w_lat  = (wr_idx % 2 == 0) ? 0 : 3;
      end
      2: begin aw_lat = 5; w_lat = 5; end
      default: begin aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); end
    endcase
  endtask

  task automatic reset_models();
    aw_got = 0; w_got = 0; in_wr = 0; wcyc = 0; b_wait = 0;
    per_start = 0; per_stop = 0; src_valid = 0; cap_addr = 0; cap_data = 0;
    pick_lat();
  endtask

  task automatic drive();
    m_axi_awready = (wcyc >= aw_lat);
    m_axi_wready  = (wcyc >= w_lat);
    m_axi_bvalid  = aw_got && w_got && (b_wait == 0);
    m_axi_bresp   = (err_on_taps && cap_addr == 32'hC) ? 2'b10 : 2'b00;
    if (!src_valid && per_start && !per_stop && $urandom_range(0, 3) != 0) begin
      src_valid = 1;
      src_data  = $urandom;
    end
    s_axis_tvalid = src_valid;
    s_axis_tdata  = src_data;
    snk_ready = (snk_mode == 0) ? 1'b1 : (snk_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
    m_axis_tready = snk_ready;
    abort = 0;
    if (abort_at > 0 && recv.size() == abort_at - 1 && src_valid && snk_ready) abort = 1;
    else if (in_wr && $urandom_range(0, 7) == 0) abort = 1;
  endtask

  task automatic sample();
    bit both_before;
    cyc++;
    both_before = aw_got && w_got;
    if (m_axi_bready) chk("bready_before_both", {63'd0, both_before}, 64'd1);
    if (m_axi_bvalid && m_axi_bready) begin
      wlog.push_back({cap_addr, cap_data});
      if (cap_addr == 32'h0) per_start = cap_data[0];
      if (cap_addr == 32'h4) per_stop  = cap_data[0];
      aw_got = 0; w_got = 0; in_wr = 0; wcyc = 0; wr_idx++;
      pick_lat();
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_duplicate", {63'd0, aw_got}, 64'd0);
        aw_got = 1; cap_addr = 32'(m_axi_awaddr);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_duplicate", {63'd0, w_got}, 64'd0);
        w_got = 1; cap_data = m_axi_wdata;
      end
      if (m_axi_awvalid || m_axi_wvalid || aw_got || w_got) begin in_wr = 1; wcyc++; end
      if (!both_before && aw_got && w_got) b_wait = $urandom_range(0, 2);
      else if (both_before && b_wait > 0) b_wait--;
    end
    if (m_axis_tvalid) begin
      chk("pass_tvalid_src", {63'd0, src_valid}, 64'd1);
      chk("pass_tdata", m_axis_tdata, src_data);
      if (snk_ready) recv.push_back(m_axis_tdata);
    end
    if (s_axis_tvalid && s_axis_tready) begin
      sent.push_back(src_data);
      src_valid = 0;
    end
    if (cmd_valid && cmd_ready) acc = 1;
    if (done) begin done_cnt++; st_beats = status_beats; st_err = status_err; end
  endtask

  task automatic tick();
    drive();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic [7:0] seed, input logic [7:0] taps, input logic [15:0] count);
    sent.delete(); recv.delete(); wlog.delete(); done_cnt = 0; acc = 0;
    cmd_seed = seed; cmd_taps = taps; cmd_count = count; cmd_valid = 1;
    for (int i = 0; i < 50 && !acc; i++) tick();
    cmd_valid = 0;
    chk("cmd_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic run_cmd(input logic [7:0] seed, input logic [7:0] taps, input int count,
                         input int ab, input bit err);
    logic [63:0] exp_w[6];
    int exp_beats;
    err_on_taps = err;
    abort_at = ab;
    issue(seed, taps, 16'(count));
    for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
    chk("done_seen", done_cnt, 1);
    exp_beats = (ab > 0 && ab < count) ? ab : count;
    chk("status_beats", st_beats, exp_beats);
    chk("status_err", {63'd0, st_err}, {63'd0, err});
    exp_w[0] = {32'h4, 32'h0};
    exp_w[1] = {32'h8, 24'h0, seed};
    exp_w[2] = {32'hC, 24'h0, taps};
    exp_w[3] = {32'h0, 32'h1};
    exp_w[4] = {32'h4, 32'h1};
    exp_w[5] = {32'h0, 32'h0};
    chk("write_count", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk($sformatf("write%0d", i), wlog[i], exp_w[i]);
    chk("fwd_count", recv.size(), exp_beats);
    for (int i = 0; i < recv.size() && i < sent.size(); i++)
      chk($sformatf("fwd_data%0d", i), recv[i], sent[i]);
    tick();
    tick();
    chk("done_once", done_cnt, 1);
    chk("beats_hold", status_beats, exp_beats);
    chk("err_hold", {63'd0, status_err}, {63'd0, err});
    abort_at = 0;
    err_on_taps = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({pfx, "_s_tready"}, {63'd0, s_axis_tready}, 64'd1);
    chk({pfx, "_awvalid"}, {63'd0, m_axi_awvalid}, 64'd0);
    chk({pfx, "_wvalid"}, {63'd0, m_axi_wvalid}, 64'd0);
    chk({pfx, "_bready"}, {63'd0, m_axi_bready}, 64'd0);
    chk({pfx, "_awaddr"}, m_axi_awaddr, 64'd0);
    chk({pfx, "_wdata"}, m_axi_wdata, 64'd0);
    chk({pfx, "_m_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    chk({pfx, "_done"}, {63'd0, done}, 64'd0);
    chk({pfx, "_status"}, {47'd0, status_err, status_beats}, 64'd0);
  endtask

  initial begin
    cmd_valid = 0; cmd_seed = 0; cmd_taps = 0; cmd_count = 0; abort = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
    s_axis_tvalid = 0; s_axis_tdata = 0; m_axis_tready = 0;
    lat_mode = 0; snk_mode = 0; cyc = 0; wr_idx = 0; abort_at = 0; err_on_taps = 0;
    src_data = 0; st_err = 0; st_beats = 0;
    reset_models();
    #1 areset = 1;
    #1 chk_reset_outputs("rst");
    @(posedge aclk); #1 areset = 0;
    tick();

    run_cmd(8'h01, 8'hB8, 4, 0, 0);

    lat_mode = 1; wr_idx = 0; pick_lat();
    run_cmd(8'($urandom), 8'($urandom), 3, 0, 0);
    lat_mode = 0;

    snk_mode = 1;
    run_cmd(8'($urandom), 8'($urandom), 5, 0, 0);
    snk_mode = 0;

    run_cmd(8'h5A, 8'hB8, 100, 7, 0);

    run_cmd(8'h33, 8'h8E, 6, 0, 1);
    run_cmd(8'h44, 8'h8E, 2, 0, 0);

    lat_mode = 2; pick_lat();
    issue(8'h77, 8'hB8, 16'd5);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (wlog.size() == 1 && m_axi_awvalid) break;
    end
    chk("in_wr_seed_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
    chk("in_wr_seed_addr", m_axi_awaddr, 64'h8);
    #2 areset = 1;
    #1 chk_reset_outputs("midrst");
    lat_mode = 0;
    reset_models();
    @(posedge aclk); #1 areset = 0;
    run_cmd(8'h12, 8'hB8, 3, 0, 0);

    run_cmd(8'h9C, 8'hB8, 0, 0, 0);

    snk_mode = 2;
    for (int k = 0; k < 6; k++) begin
      int c, a;
      c = $urandom_range(1, 20);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, c) : 0;
      run_cmd(8'($urandom), 8'($urandom), c, a, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
